// File: rtl/inst_trace_buffer.sv
// Retire-trace recorder: decodes each retired MIPS instruction to ASCII and logs
// {pc, instr, mnemonic} in a ring buffer with arm/trigger/post-trigger freeze.
module inst_trace_buffer #(
   parameter int DEPTH       = 16,
   parameter int CHARS       = 6,
   parameter int POST_TRIG   = 4,
   parameter int TRIG_ON_EXC = 1,
   localparam int AW         = $clog2(DEPTH),
   localparam int ASCII_W    = 8 * CHARS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_valid,
   input  logic [31:0]        wb_pc,
   input  logic [31:0]        wb_instr,
   input  logic               wb_excep,
   input  logic               arm,
   input  logic [31:0]        trig_mask,
   input  logic [31:0]        trig_value,
   input  logic               rd_en,
   input  logic [AW-1:0]      rd_idx,
   output logic               rd_valid,
   output logic [31:0]        rd_pc,
   output logic [31:0]        rd_instr,
   output logic [ASCII_W-1:0] rd_ascii,
   output logic [AW:0]        entries,
   output logic [1:0]         state,
   output logic [31:0]        trig_pc,
   output logic [31:0]        retired_cnt
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, POST = 2'd2, FROZEN = 2'd3} state_t;

   localparam int            ENTRY_W = 64 + ASCII_W;
   localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] PT_INIT = AW'(POST_TRIG);

   // Mnemonics are 8 characters, left-justified and space-padded.
   function automatic logic [63:0] decode(input logic [31:0] ins);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [63:0] m;
      op = ins[31:26];
      fn = ins[5:0];
      rs = ins[25:21];
      rt = ins[20:16];
      m  = "N-R     ";
      if (ins == 32'd0) begin
         m = "NOP     ";
      end else begin
         case (op)
            6'h00: case (fn)
               6'h00: m = "SLL     ";
               6'h02: m = "SRL     ";
               6'h03: m = "SRA     ";
               6'h04: m = "SLLV    ";
               6'h06: m = "SRLV    ";
               6'h07: m = "SRAV    ";
               6'h08: m = "JR      ";
               6'h09: m = "JALR    ";
               6'h0C: m = "SYSC    ";
               6'h0D: m = "BREAK   ";
               6'h0F: m = "SYNC    ";
               6'h10: m = "MFHI    ";
               6'h11: m = "MTHI    ";
               6'h12: m = "MFLO    ";
               6'h13: m = "MTLO    ";
               6'h18: m = "MULT    ";
               6'h19: m = "MULTU   ";
               6'h1A: m = "DIV     ";
               6'h1B: m = "DIVU    ";
               6'h20: m = "ADD     ";
               6'h21: m = "ADDU    ";
               6'h22: m = "SUB     ";
               6'h23: m = "SUBU    ";
               6'h24: m = "AND     ";
               6'h25: m = "OR      ";
               6'h26: m = "XOR     ";
               6'h27: m = "NOR     ";
               6'h2A: m = "SLT     ";
               6'h2B: m = "SLTU    ";
               default: ;
            endcase
            6'h01: case (rt)
               5'h00: m = "BLTZ    ";
               5'h01: m = "BGEZ    ";
               5'h10: m = "BLTZAL  ";
               5'h11: m = "BGEZAL  ";
               default: ;
            endcase
            6'h02: m = "J       ";
            6'h03: m = "JAL     ";
            6'h04: m = "BEQ     ";
            6'h05: m = "BNE     ";
            6'h06: m = "BLEZ    ";
            6'h07: m = "BGTZ    ";
            6'h08: m = "ADDI    ";
            6'h09: m = "ADDIU   ";
            6'h0A: m = "SLTI    ";
            6'h0B: m = "SLTIU   ";
            6'h0C: m = "ANDI    ";
            6'h0D: m = "ORI     ";
            6'h0E: m = "XORI    ";
            6'h0F: m = "LUI     ";
            6'h10: begin
               if (rs == 5'h00)      m = "MFC0    ";
               else if (rs == 5'h04) m = "MTC0    ";
               else if (rs[4]) begin
                  case (fn)
                     6'h01: m = "TLBR    ";
                     6'h02: m = "TLBWI   ";
                     6'h08: m = "TLBP    ";
                     6'h18: m = "ERET    ";
                     6'h20: m = "WAIT    ";
                     default: ;
                  endcase
               end
            end
            6'h1C: case (fn)
               6'h00: m = "MADD    ";
               6'h01: m = "MADDU   ";
               6'h02: m = "MUL     ";
               6'h04: m = "MSUB    ";
               6'h05: m = "MSUBU   ";
               6'h20: m = "CLZ     ";
               6'h21: m = "CLO     ";
               default: ;
            endcase
            6'h20: m = "LB      ";
            6'h21: m = "LH      ";
            6'h22: m = "LWL     ";
            6'h23: m = "LW      ";
            6'h24: m = "LBU     ";
            6'h25: m = "LHU     ";
            6'h26: m = "LWR     ";
            6'h28: m = "SB      ";
            6'h29: m = "SH      ";
            6'h2A: m = "SWL     ";
            6'h2B: m = "SW      ";
            6'h2E: m = "SWR     ";
            6'h2F: m = "CACHE   ";
            6'h30: m = "LL      ";
            6'h33: m = "PREF    ";
            6'h38: m = "SC      ";
            default: ;
         endcase
      end
      return m;
   endfunction

   state_t             state_q;
   logic [AW-1:0]      wr_ptr_q;
   logic [AW:0]        entries_q;
   logic [AW-1:0]      post_cnt_q;
   logic [31:0]        trig_pc_q;
   logic [31:0]        retired_q;
   logic               rd_valid_q;
   logic [ENTRY_W-1:0] rd_data_q;
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [63:0]        mnem_d;
   logic [ASCII_W-1:0] ascii_d;
   logic               cap_d;
   logic               trig_d;
   logic [AW-1:0]      rd_addr_d;
   logic               rd_hit_d;
   logic               unused_mnem;

   assign mnem_d      = decode(wb_instr);
   assign unused_mnem = ^mnem_d;

   // Truncate to CHARS characters, or pad with spaces beyond the 8-char table.
   for (genvar gi = 0; gi < CHARS; gi++) begin : g_char
      if (gi < 8) begin : g_txt
         assign ascii_d[ASCII_W-1-8*gi -: 8] = mnem_d[63-8*gi -: 8];
      end else begin : g_pad
         assign ascii_d[ASCII_W-1-8*gi -: 8] = 8'h20;
      end
   end

   always_comb begin
      cap_d  = !rst && !arm && wb_valid && (state_q == RUN || state_q == POST);
      trig_d = wb_valid && (((wb_instr & trig_mask) == trig_value) ||
                            ((TRIG_ON_EXC != 0) && wb_excep));
      // Once the ring has wrapped, the oldest entry sits at the write pointer.
      rd_addr_d = ((entries_q == FULL) ? wr_ptr_q : '0) + rd_idx;
      rd_hit_d  = rd_en && ({1'b0, rd_idx} < entries_q);
   end

   always_ff @(posedge clk) begin
      if (cap_d) mem_q[wr_ptr_q] <= {wb_pc, wb_instr, ascii_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_hit_d;
         rd_data_q  <= rd_hit_d ? mem_q[rd_addr_d] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         entries_q  <= '0;
         post_cnt_q <= '0;
         trig_pc_q  <= '0;
         retired_q  <= '0;
      end else if (arm) begin
         state_q    <= RUN;
         wr_ptr_q   <= '0;
         entries_q  <= '0;
         post_cnt_q <= '0;
         trig_pc_q  <= '0;
         retired_q  <= '0;
      end else begin
         if (cap_d) begin
            wr_ptr_q  <= wr_ptr_q + AW'(1);
            retired_q <= retired_q + 32'd1;
            if (entries_q != FULL) entries_q <= entries_q + (AW + 1)'(1);
         end
         case (state_q)
            RUN: if (trig_d) begin
               trig_pc_q <= wb_pc;
               if (POST_TRIG == 0) begin
                  state_q <= FROZEN;
               end else begin
                  post_cnt_q <= PT_INIT;
                  state_q    <= POST;
               end
            end
            POST: if (wb_valid) begin
               post_cnt_q <= post_cnt_q - AW'(1);
               if (post_cnt_q == AW'(1)) state_q <= FROZEN;
            end
            default: ;
         endcase
      end
   end

   assign rd_valid    = rd_valid_q;
   assign rd_pc       = rd_data_q[ENTRY_W-1 -: 32];
   assign rd_instr    = rd_data_q[ENTRY_W-33 -: 32];
   assign rd_ascii    = rd_data_q[ASCII_W-1:0];
   assign entries     = entries_q;
   assign state       = state_q;
   assign trig_pc     = trig_pc_q;
   assign retired_cnt = retired_q;
endmodule

// File: tb/tb_inst_trace_buffer.sv
// Directed bench for inst_trace_buffer (DEPTH=4, POST_TRIG=2) with a capture
// model and a read scoreboard.
module tb_inst_trace_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic        clk = 1'b0;
   logic        rst, wb_valid, wb_excep, arm, rd_en;
   logic [31:0] wb_pc, wb_instr, trig_mask, trig_value;
   logic [AW-1:0] rd_idx;
   logic        rd_valid;
   logic [31:0] rd_pc, rd_instr, trig_pc, retired_cnt;
   logic [47:0] rd_ascii;
   logic [AW:0] entries;
   logic [1:0]  state;

   inst_trace_buffer #(.DEPTH(DEPTH), .CHARS(6), .POST_TRIG(2), .TRIG_ON_EXC(1)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
      .wb_excep(wb_excep), .arm(arm), .trig_mask(trig_mask), .trig_value(trig_value),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_pc(rd_pc),
      .rd_instr(rd_instr), .rd_ascii(rd_ascii), .entries(entries), .state(state),
      .trig_pc(trig_pc), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [47:0] ascii;
   } rec_t;

   rec_t        cap_q[$];   // buffered entries, oldest first
   rec_t        exp_q[$];   // expected read results
   int unsigned model_cnt = 0;
   int          n_pass = 0, n_fail = 0, n_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic exc,
                         input logic [47:0] asc, input logic cap);
      wb_valid = 1'b1; wb_pc = pc; wb_instr = instr; wb_excep = exc;
      tick();
      wb_valid = 1'b0; wb_excep = 1'b0;
      $display("retire pc=%08h instr=%08h exc=%0b state=%0d", pc, instr, exc, state);
      if (cap) begin
         cap_q.push_back({1'b1, pc, instr, asc});
         if (cap_q.size() > DEPTH) cap_q.delete(0);
         model_cnt++;
      end
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      cap_q.delete();
      model_cnt = 0;
      $display("arm state=%0d", state);
   endtask

   task automatic read(input int idx);
      rec_t e;
      e = '0;
      if (idx < cap_q.size()) e = cap_q[idx];
      exp_q.push_back(e);
      rd_en = 1'b1; rd_idx = AW'(idx);
      tick();
      rd_en = 1'b0;
      e = exp_q.pop_front();
      $display("read idx=%0d valid=%0b pc=%08h instr=%08h ascii=\"%s\"", idx, rd_valid, rd_pc, rd_instr, rd_ascii);
      check($sformatf("rd%0d_valid", idx), 64'(rd_valid), 64'(e.v));
      check($sformatf("rd%0d_pc", idx), 64'(rd_pc), 64'(e.pc));
      check($sformatf("rd%0d_instr", idx), 64'(rd_instr), 64'(e.instr));
      check($sformatf("rd%0d_ascii", idx), 64'(rd_ascii), 64'(e.ascii));
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_entries"}, 64'(entries), 64'(cap_q.size()));
      check({tag, "_retired"}, 64'(retired_cnt), 64'(model_cnt));
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b0; wb_excep = 1'b0; arm = 1'b0; rd_en = 1'b0;
      wb_pc = '0; wb_instr = '0; rd_idx = '0;
      trig_mask = 32'hFFFF_FFFF; trig_value = 32'hFFFF_FFFF;
      tick(); tick();
      rst = 1'b0;
      check("rst_state", 64'(state), 64'd0);
      check("rst_entries", 64'(entries), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_pc", 64'(rd_pc), 64'd0);
      check("rst_trig_pc", 64'(trig_pc), 64'd0);
      check("rst_retired", 64'(retired_cnt), 64'd0);

      // Basic capture and decode
      do_arm();
      check("arm_state", 64'(state), 64'd1);
      retire(32'hBFC0_0000, 32'h2402_0005, 1'b0, "ADDIU ", 1'b1);
      retire(32'hBFC0_0004, 32'h0000_0000, 1'b0, "NOP   ", 1'b1);
      retire(32'hBFC0_0008, 32'h0043_0821, 1'b0, "ADDU  ", 1'b1);
      check_counts("basic");
      for (int i = 0; i < 4; i++) read(i);   // idx 3 is past the valid range

      // Wrap: six captures into four entries
      do_arm();
      retire(32'h0000_0000, 32'h8C43_0004, 1'b0, "LW    ", 1'b1);
      retire(32'h0000_0004, 32'hAC43_0008, 1'b0, "SW    ", 1'b1);
      retire(32'h0000_0008, 32'h3C01_1234, 1'b0, "LUI   ", 1'b1);
      retire(32'h0000_000C, 32'h1022_0003, 1'b0, "BEQ   ", 1'b1);
      retire(32'h0000_0010, 32'h0003_1080, 1'b0, "SLL   ", 1'b1);
      retire(32'h0000_0014, 32'h0000_000C, 1'b0, "SYSC  ", 1'b1);
      check_counts("wrap");
      for (int i = 0; i < 4; i++) read(i);

      // Trigger on JAL, two post captures, then frozen
      do_arm();
      trig_mask = 32'hFC00_0000; trig_value = 32'h0C00_0000;
      retire(32'h0000_00FC, 32'h0043_0821, 1'b0, "ADDU  ", 1'b1);
      check("pre_trig_state", 64'(state), 64'd1);
      retire(32'h0000_0100, 32'h0C00_0040, 1'b0, "JAL   ", 1'b1);
      check("trig_state", 64'(state), 64'd2);
      check("trig_pc", 64'(trig_pc), 64'h100);
      retire(32'h0000_0104, 32'h0C00_0080, 1'b0, "JAL   ", 1'b1);
      check("post1_state", 64'(state), 64'd2);
      check("post1_trig_pc", 64'(trig_pc), 64'h100);
      retire(32'h0000_0108, 32'h2402_0005, 1'b0, "ADDIU ", 1'b1);
      check("frozen_state", 64'(state), 64'd3);
      retire(32'h0000_010C, 32'h2402_0005, 1'b0, "ADDIU ", 1'b0);
      check("frozen_hold_state", 64'(state), 64'd3);
      check_counts("frozen");
      for (int i = 0; i < 4; i++) read(i);

      // Exception trigger, then arm colliding with a matching retire
      do_arm();
      check("rearm_state", 64'(state), 64'd1);
      trig_mask = 32'hFFFF_FFFF; trig_value = 32'hFFFF_FFFF;
      retire(32'h0000_0200, 32'h2402_0005, 1'b1, "ADDIU ", 1'b1);
      check("exc_state", 64'(state), 64'd2);
      check("exc_trig_pc", 64'(trig_pc), 64'h200);
      trig_mask = 32'h0; trig_value = 32'h0;
      arm = 1'b1; wb_valid = 1'b1; wb_pc = 32'h204; wb_instr = 32'h2402_0005;
      tick();
      arm = 1'b0; wb_valid = 1'b0;
      cap_q.delete(); model_cnt = 0;
      $display("arm+retire state=%0d entries=%0d", state, entries);
      check("armwin_state", 64'(state), 64'd1);
      check("armwin_trig_pc", 64'(trig_pc), 64'd0);
      check_counts("armwin");

      // Decode edge cases
      trig_mask = 32'hFFFF_FFFF; trig_value = 32'hFFFF_FFFF;
      retire(32'h0000_0400, 32'hFC00_0000, 1'b0, "N-R   ", 1'b1);
      retire(32'h0000_0404, 32'h0411_0000, 1'b0, "BGEZAL", 1'b1);
      retire(32'h0000_0408, 32'h4200_0018, 1'b0, "ERET  ", 1'b1);
      retire(32'h0000_040C, 32'h7000_0020, 1'b0, "CLZ   ", 1'b1);
      check_counts("decode");
      for (int i = 0; i < 4; i++) read(i);

      // Reset while in POST
      trig_mask = 32'h0; trig_value = 32'h0;
      retire(32'h0000_0300, 32'h2402_0005, 1'b0, "ADDIU ", 1'b1);
      check("post2_state", 64'(state), 64'd2);
      check("post2_trig_pc", 64'(trig_pc), 64'h300);
      rst = 1'b1; wb_valid = 1'b1; rd_en = 1'b1; rd_idx = '0;
      tick();
      rst = 1'b0; wb_valid = 1'b0; rd_en = 1'b0;
      $display("reset-in-post state=%0d entries=%0d", state, entries);
      check("rst2_state", 64'(state), 64'd0);
      check("rst2_entries", 64'(entries), 64'd0);
      check("rst2_rd_valid", 64'(rd_valid), 64'd0);
      check("rst2_rd_pc", 64'(rd_pc), 64'd0);
      check("rst2_trig_pc", 64'(trig_pc), 64'd0);
      check("rst2_retired", 64'(retired_cnt), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
